// File: rtl/unidade_controle_exp6_pkg.sv
// Shared state codes and control-strobe bundle for the memory-game control unit.
package unidade_controle_exp6_pkg;

  // State codes; these values are also what db_estado shows
  localparam logic [3:0] ST_INICIAL        = 4'h0;
  localparam logic [3:0] ST_PREPARACAO     = 4'h1;
  localparam logic [3:0] ST_INICIA_RODADA  = 4'h2;
  localparam logic [3:0] ST_ESPERA_JOGADA  = 4'h3;
  localparam logic [3:0] ST_REGISTRA       = 4'h4;
  localparam logic [3:0] ST_COMPARACAO     = 4'h5;
  localparam logic [3:0] ST_PROXIMA_JOGADA = 4'h6;
  localparam logic [3:0] ST_PROXIMA_RODADA = 4'h7;
  localparam logic [3:0] ST_FIM_ACERTOU    = 4'hA;
  localparam logic [3:0] ST_FIM_TIMEOUT    = 4'hD;
  localparam logic [3:0] ST_FIM_ERROU      = 4'hE;

  // All Moore outputs grouped so the decoder can default them in one go
  typedef struct packed {
    logic zera_e;
    logic conta_e;
    logic zera_rod;
    logic conta_rod;
    logic zera_t;
    logic conta_t;
    logic zera_r;
    logic registra_r;
    logic pronto;
    logic acertou;
    logic errou;
    logic timeout;
  } ctrl_t;

  // End states share the same exit: wait for iniciar, then restart
  function automatic logic is_end_state(input logic [3:0] st);
    return (st == ST_FIM_ACERTOU) || (st == ST_FIM_ERROU) || (st == ST_FIM_TIMEOUT);
  endfunction

endpackage

// File: rtl/unidade_controle_exp6.sv
// Moore control unit sequencing the memory-game datapath (rounds, plays, timeout).
module unidade_controle_exp6
  import unidade_controle_exp6_pkg::*;
#(
  parameter bit HAS_TIMEOUT = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       enderecoIgualRodada,
  input  logic       fimRod,
  input  logic       fimT,
  input  logic       fimE,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraRod,
  output logic       contaRod,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  logic [3:0] estado_q;
  logic [3:0] estado_d;
  ctrl_t      ctrl;

  // fimE is reserved for a future end-of-sequence check
  logic unused_fime;
  assign unused_fime = fimE;

  // State register with synchronous reset to inicial
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= ST_INICIAL;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic; a play pulse outranks a simultaneous timer expiry
  always_comb begin
    estado_d = ST_INICIAL;
    case (estado_q)
      ST_INICIAL:        estado_d = iniciar ? ST_PREPARACAO : ST_INICIAL;
      ST_PREPARACAO:     estado_d = ST_INICIA_RODADA;
      ST_INICIA_RODADA:  estado_d = ST_ESPERA_JOGADA;
      ST_ESPERA_JOGADA: begin
        if (jogada_feita) begin
          estado_d = ST_REGISTRA;
        end else if (fimT && HAS_TIMEOUT) begin
          estado_d = ST_FIM_TIMEOUT;
        end else begin
          estado_d = ST_ESPERA_JOGADA;
        end
      end
      ST_REGISTRA:       estado_d = ST_COMPARACAO;
      ST_COMPARACAO: begin
        if (!igual) begin
          estado_d = ST_FIM_ERROU;
        end else if (enderecoIgualRodada && fimRod) begin
          estado_d = ST_FIM_ACERTOU;
        end else if (enderecoIgualRodada) begin
          estado_d = ST_PROXIMA_RODADA;
        end else begin
          estado_d = ST_PROXIMA_JOGADA;
        end
      end
      ST_PROXIMA_JOGADA: estado_d = ST_ESPERA_JOGADA;
      ST_PROXIMA_RODADA: estado_d = ST_INICIA_RODADA;
      default: begin
        if (is_end_state(estado_q)) begin
          estado_d = iniciar ? ST_PREPARACAO : estado_q;
        end else begin
          estado_d = ST_INICIAL;
        end
      end
    endcase
  end

  // Output decode from the current state only; unlisted strobes stay low
  always_comb begin
    ctrl = '0;
    case (estado_q)
      ST_PREPARACAO: begin
        ctrl.zera_e   = 1'b1;
        ctrl.zera_rod = 1'b1;
        ctrl.zera_r   = 1'b1;
        ctrl.zera_t   = 1'b1;
      end
      ST_INICIA_RODADA: begin
        ctrl.zera_e = 1'b1;
        ctrl.zera_t = 1'b1;
      end
      ST_ESPERA_JOGADA:  ctrl.conta_t    = HAS_TIMEOUT;
      ST_REGISTRA:       ctrl.registra_r = 1'b1;
      ST_PROXIMA_JOGADA: begin
        ctrl.conta_e = 1'b1;
        ctrl.zera_t  = 1'b1;
      end
      ST_PROXIMA_RODADA: ctrl.conta_rod = 1'b1;
      ST_FIM_ACERTOU: begin
        ctrl.pronto  = 1'b1;
        ctrl.acertou = 1'b1;
      end
      ST_FIM_ERROU: begin
        ctrl.pronto = 1'b1;
        ctrl.errou  = 1'b1;
      end
      ST_FIM_TIMEOUT: begin
        ctrl.pronto  = 1'b1;
        ctrl.timeout = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign zeraE     = ctrl.zera_e;
  assign contaE    = ctrl.conta_e;
  assign zeraRod   = ctrl.zera_rod;
  assign contaRod  = ctrl.conta_rod;
  assign zeraT     = ctrl.zera_t;
  assign contaT    = ctrl.conta_t;
  assign zeraR     = ctrl.zera_r;
  assign registraR = ctrl.registra_r;
  assign pronto    = ctrl.pronto;
  assign acertou   = ctrl.acertou;
  assign errou     = ctrl.errou;
  assign timeout   = ctrl.timeout;
  assign db_estado = estado_q;

endmodule
